updown_counter_mod: RTL

Parametrised synchronous up/down counter with modulo/saturate modes, built-in enable prescaler, parallel load, sync clear, and terminal-count/overflow flags. Next generation of the fixed 8-bit behavioural counter. Used as timer, event counter and address sequencer. It has true and complemented outputs and registered status.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/updown_counter_mod_if.sv | 31 +++
 rtl/counter_prescaler.sv | 47 ++++
 rtl/updown_counter_mod.sv | 102 ++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
//------------------------------------------------------------------------------
// counter_pkg : shared helpers and mode constants for the up/down counter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Bits needed to hold 0..value-1, never less than 1.
  function automatic int clog2_safe(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/updown_counter_mod_if.sv
//------------------------------------------------------------------------------
// updown_counter_mod_if : control and status bundle of the up/down counter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface updown_counter_mod_if #(
  parameter int WIDTH = 8
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             en;
  logic             up_down;
  logic [WIDTH-1:0] qd;
  logic [WIDTH-1:0] qd_b;
  logic             tc;
  logic             ovf;

  modport master (
    output clear, load, d, en, up_down,
    input  qd, qd_b, tc, ovf
  );

  modport slave (
    input  clear, load, d, en, up_down,
    output qd, qd_b, tc, ovf
  );
endinterface

`default_nettype wire

// File: rtl/counter_prescaler.sv
//------------------------------------------------------------------------------
// counter_prescaler : divides enabled cycles by PRESCALE into a one-cycle tick
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic en,
  output logic tick
);

  localparam int PW = clog2_safe(PRESCALE);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, restart};
      assign tick     = en;
    end else begin : g_divide
      localparam logic [PW-1:0] c_last = PW'(PRESCALE - 1);
      logic [PW-1:0] r_phase;

      assign tick = en && (r_phase == c_last);

      // Phase only advances on enabled cycles, so en=0 freezes it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_phase <= '0;
        end else if (restart) begin
          r_phase <= '0;
        end else if (en) begin
          r_phase <= (r_phase == c_last) ? '0 : r_phase + PW'(1);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/updown_counter_mod.sv
//------------------------------------------------------------------------------
// updown_counter_mod : up/down counter, wrap/saturate, prescaler, load, clear
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     SATURATE = CNT_WRAP,
  parameter int     PRESCALE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  updown_counter_mod_if.slave  bus
);

  generate
    if (WIDTH < 2 || WIDTH > 32 || MODULUS < 2 ||
        MODULUS > (longint'(1) << WIDTH) || PRESCALE < 1 || PRESCALE > 65536) begin : g_param_err
      $error("updown_counter_mod: illegal parameters WIDTH=%0d MODULUS=%0d PRESCALE=%0d",
             WIDTH, MODULUS, PRESCALE);
    end
  endgenerate

  localparam logic [WIDTH:0] c_max = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] c_one = (WIDTH+1)'(1);
  localparam bit             c_sat = (SATURATE == CNT_SAT);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;

  logic             w_tick;
  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_d_ext;
  logic [WIDTH:0]   w_load_ext;
  logic [WIDTH:0]   w_step_ext;
  logic             w_boundary;
  logic             w_unused_msb;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (bus.clear | bus.load),
    .en      (bus.en),
    .tick    (w_tick)
  );

  assign w_q_ext      = {1'b0, r_q};
  assign w_d_ext      = {1'b0, bus.d};
  assign w_load_ext   = (w_d_ext > c_max) ? c_max : w_d_ext;
  assign w_boundary   = bus.up_down ? (w_q_ext == c_max) : (r_q == '0);
  assign w_unused_msb = w_step_ext[WIDTH] ^ w_load_ext[WIDTH];

  always_comb begin
    w_step_ext = w_q_ext;
    if (w_boundary) begin
      if (c_sat)            w_step_ext = w_q_ext;
      else if (bus.up_down) w_step_ext = '0;
      else                  w_step_ext = c_max;
    end else if (bus.up_down) begin
      w_step_ext = w_q_ext + c_one;
    end else begin
      w_step_ext = w_q_ext - c_one;
    end
  end

  // tc is a one-cycle pulse; ovf is sticky until clear or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (bus.clear) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else if (bus.load) begin
      r_q   <= w_load_ext[WIDTH-1:0];
      r_tc  <= 1'b0;
    end else if (w_tick) begin
      r_q   <= w_step_ext[WIDTH-1:0];
      r_tc  <= w_boundary;
      r_ovf <= r_ovf | w_boundary;
    end else begin
      r_tc  <= 1'b0;
    end
  end

  assign bus.qd   = r_q;
  assign bus.qd_b = ~r_q;
  assign bus.tc   = r_tc;
  assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire
